// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send, then clocks
// one command byte out on device-generated falling edges and reports ACK, NACK or timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o,
  output logic [1:0] err_code_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int unsigned MaxCycles = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                         : TIMEOUT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [1:0] ErrTimeout = 2'b01;
  localparam logic [1:0] ErrNack    = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StXfer,
    StAck,
    StWaitIdle,
    StDone,
    StErr
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      nfall_q;
  logic [7:0]      data_q;
  logic            parity_q;
  logic            clk_s1_q, clk_s2_q, clk_prev_q;
  logic            data_s1_q, data_s2_q;
  logic            clk_oe_q, data_oe_q;
  logic            done_q, err_q;
  logic [1:0]      err_code_q;

  logic fall;
  logic timeout;
  logic drive_low;

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Data-line level the host wants for the current state and bit position.
  always_comb begin
    drive_low = 1'b0;
    unique case (state_q)
      StReq: drive_low = 1'b1;
      StXfer: begin
        if (nfall_q == 4'd0) begin
          drive_low = 1'b1;
        end else if (nfall_q <= 4'd8) begin
          drive_low = ~data_q[3'(nfall_q - 4'd1)];
        end else if (nfall_q == 4'd9) begin
          drive_low = ~parity_q;
        end else begin
          drive_low = 1'b0;
        end
      end
      default: drive_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      nfall_q    <= 4'd0;
      data_q     <= 8'h00;
      parity_q   <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_i;
      data_s2_q  <= data_s1_q;

      clk_oe_q   <= (state_q == StInhibit) || (state_q == StReq);
      data_oe_q  <= drive_low;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;

      unique case (state_q)
        StIdle: begin
          if (tx_valid_i) begin
            data_q   <= tx_data_i;
            parity_q <= ~^tx_data_i;
            cnt_q    <= '0;
            state_q  <= StInhibit;
          end
        end
        StInhibit: begin
          if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
            state_q <= StReq;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StReq: begin
          cnt_q   <= '0;
          nfall_q <= 4'd0;
          state_q <= StXfer;
        end
        StXfer: begin
          // A device edge takes priority over an expiring timeout.
          if (fall) begin
            cnt_q   <= '0;
            nfall_q <= nfall_q + 4'd1;
            if (nfall_q == 4'd9) begin
              state_q <= StAck;
            end
          end else if (timeout) begin
            err_q      <= 1'b1;
            err_code_q <= ErrTimeout;
            state_q    <= StErr;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StAck: begin
          if (fall) begin
            cnt_q <= '0;
            if (data_s2_q) begin
              err_q      <= 1'b1;
              err_code_q <= ErrNack;
              state_q    <= StErr;
            end else begin
              state_q <= StWaitIdle;
            end
          end else if (timeout) begin
            err_q      <= 1'b1;
            err_code_q <= ErrTimeout;
            state_q    <= StErr;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitIdle: begin
          if (clk_s2_q && data_s2_q) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (fall) begin
            cnt_q <= '0;
          end else if (timeout) begin
            err_q      <= 1'b1;
            err_code_q <= ErrTimeout;
            state_q    <= StErr;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_ready_o    = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign tx_done_o     = done_q;
  assign tx_err_o      = err_q;
  assign err_code_o    = err_code_q;
  assign ps2_clk_oe_o  = clk_oe_q;
  assign ps2_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 keyboard on an open-drain bus captures each
// frame, which is compared against the frame built from the byte by simple bit counting.
module tb_ps2_host_tx;

  localparam int unsigned Inhibit = 100;
  localparam int unsigned Timeout = 5000;
  localparam int          Half    = 20;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       clk_oe, data_oe;
  logic       ps2_clk_line, ps2_data_line;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [1:0] last_code = 2'b00;

  always #5 clk_i = ~clk_i;

  assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
  assign ps2_data_line = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(Inhibit),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .busy_o       (busy),
    .tx_done_o    (tx_done),
    .tx_err_o     (tx_err),
    .err_code_o   (err_code),
    .ps2_clk_i    (ps2_clk_line),
    .ps2_data_i   (ps2_data_line),
    .ps2_clk_oe_o (clk_oe),
    .ps2_data_oe_o(data_oe)
  );

  always @(negedge clk_i) begin
    if (tx_done) done_cnt++;
    if (tx_err) begin
      err_cnt++;
      last_code = err_code;
    end
    if (tx_done && tx_err) both_cnt++;
  end

  // Frame as the device sees it: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i + 1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic dev_frame(input int nclk, input bit ack, output logic [10:0] bits,
                           output bit ok);
    ok   = 1'b0;
    bits = '0;
    for (int i = 0; i < int'(Inhibit) + 200 && !ok; i++) begin
      @(negedge clk_i);
      if (ps2_clk_line && !ps2_data_line) ok = 1'b1;
    end
    if (!ok) return;
    repeat (10) @(negedge clk_i);
    bits[0] = ps2_data_line;
    for (int k = 1; k <= 10 && k <= nclk; k++) begin
      dev_clk_low = 1'b1;
      repeat (Half) @(negedge clk_i);
      dev_clk_low = 1'b0;
      bits[k] = ps2_data_line;
      repeat (Half / 2) @(negedge clk_i);
      if (k == 10 && nclk >= 11) dev_data_low = ack;
      repeat (Half / 2) @(negedge clk_i);
    end
    if (nclk >= 11) begin
      dev_clk_low = 1'b1;
      repeat (Half) @(negedge clk_i);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk_i);
      dev_data_low = 1'b0;
      repeat (Half) @(negedge clk_i);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk_i);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk_i);
    tx_valid = 1'b0;
  endtask

  task automatic wait_end(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_i);
      if (tx_done || tx_err) seen = 1'b1;
    end
    @(negedge clk_i);
  endtask

  task automatic run_frame(input logic [7:0] b, input int nclk, input bit ack,
                           output logic [10:0] bits, output bit ok, output bit seen);
    logic [10:0] got;
    bit          dok;
    fork
      start_tx(b);
      dev_frame(nclk, ack, got, dok);
    join
    bits = got;
    ok   = dok;
    wait_end(seen);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++;
    if ({clk_oe, data_oe, tx_done, tx_err, err_code, busy, tx_ready} !== 8'b0000_0001)
      $display("FAIL reset_outputs got=%b exp=%b",
               {clk_oe, data_oe, tx_done, tx_err, err_code, busy, tx_ready}, 8'b0000_0001);
    else passed++;
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    checks++;
    if ({clk_oe, data_oe, tx_ready} !== 3'b001)
      $display("FAIL idle_after_reset got=%b exp=001", {clk_oe, data_oe, tx_ready});
    else passed++;
  endtask

  task automatic test_send_ed();
    logic [10:0] bits;
    bit ok, seen;
    int inh, req, guard, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    inh = 0;
    req = 0;
    guard = 0;
    fork
      begin
        start_tx(8'hED);
        while (!clk_oe && guard < 5) begin
          @(negedge clk_i);
          guard++;
        end
        while (clk_oe && !data_oe && inh < int'(Inhibit) + 50) begin
          inh++;
          @(negedge clk_i);
        end
        while (clk_oe && data_oe && req < 10) begin
          req++;
          @(negedge clk_i);
        end
      end
      dev_frame(11, 1'b1, bits, ok);
    join
    wait_end(seen);
    checks++;
    if (ok !== 1'b1) $display("FAIL ed_request got=%b exp=1", ok); else passed++;
    checks++;
    if (bits !== frame_of(8'hED))
      $display("FAIL ed_bits got=%b exp=%b", bits, frame_of(8'hED));
    else passed++;
    checks++;
    if (inh !== int'(Inhibit)) $display("FAIL ed_inhibit got=%0d exp=%0d", inh, Inhibit);
    else passed++;
    checks++;
    if (req !== 1) $display("FAIL ed_req_cycles got=%0d exp=1", req); else passed++;
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL ed_done got=%0d exp=1", done_cnt - d0);
    else passed++;
    checks++;
    if (err_cnt - e0 !== 0) $display("FAIL ed_err got=%0d exp=0", err_cnt - e0);
    else passed++;
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL ed_ready_after got=%b exp=1", tx_ready);
    else passed++;
  endtask

  task automatic test_parity();
    logic [7:0] vals[8];
    logic [10:0] bits;
    bit ok, seen;
    int d0;
    vals[0] = 8'h01;
    vals[1] = 8'h00;
    for (int i = 2; i < 8; i++) vals[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt;
      run_frame(vals[i], 11, 1'b1, bits, ok, seen);
      checks++;
      if (bits !== frame_of(vals[i]))
        $display("FAIL byte_%0h_bits got=%b exp=%b", vals[i], bits, frame_of(vals[i]));
      else passed++;
      checks++;
      if (done_cnt - d0 !== 1)
        $display("FAIL byte_%0h_done got=%0d exp=1", vals[i], done_cnt - d0);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    int cnt, guard, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hA5);
    guard = 0;
    while (!clk_oe && guard < 10) begin
      @(negedge clk_i);
      guard++;
    end
    guard = 0;
    while (clk_oe && guard < int'(Inhibit) + 20) begin
      @(negedge clk_i);
      guard++;
    end
    // The clock enable drops one cycle after the state enters the transfer phase.
    cnt = 1;
    while (!tx_err && cnt < int'(Timeout) + 100) begin
      @(negedge clk_i);
      cnt++;
    end
    checks++;
    if (cnt !== int'(Timeout)) $display("FAIL timeout_cycles got=%0d exp=%0d", cnt, Timeout);
    else passed++;
    checks++;
    if (err_code !== 2'b01) $display("FAIL timeout_code got=%b exp=01", err_code);
    else passed++;
    @(negedge clk_i);
    checks++;
    if ({clk_oe, data_oe} !== 2'b00)
      $display("FAIL timeout_release got=%b exp=00", {clk_oe, data_oe});
    else passed++;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({err_cnt - e0, done_cnt - d0} !== {32'd1, 32'd0})
      $display("FAIL timeout_pulses got=%0d/%0d exp=1/0", err_cnt - e0, done_cnt - d0);
    else passed++;
  endtask

  task automatic test_nack();
    logic [7:0] b;
    logic [10:0] bits;
    bit ok, seen;
    int d0, e0;
    b = 8'($urandom_range(0, 255));
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(b, 11, 1'b0, bits, ok, seen);
    checks++;
    if (bits !== frame_of(b)) $display("FAIL nack_bits got=%b exp=%b", bits, frame_of(b));
    else passed++;
    checks++;
    if (err_cnt - e0 !== 1) $display("FAIL nack_err got=%0d exp=1", err_cnt - e0);
    else passed++;
    checks++;
    if (last_code !== 2'b10) $display("FAIL nack_code got=%b exp=10", last_code);
    else passed++;
    checks++;
    if (done_cnt - d0 !== 0) $display("FAIL nack_done got=%0d exp=0", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits, ref_f;
    bit ok, seen;
    logic pre;
    int d0;
    ref_f = frame_of(8'hED);
    fork
      start_tx(8'hED);
      dev_frame(5, 1'b1, bits, ok);
    join
    pre = data_oe;
    checks++;
    if (pre !== ~ref_f[5]) $display("FAIL midframe_drive got=%b exp=%b", pre, ~ref_f[5]);
    else passed++;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({clk_oe, data_oe, busy} !== 3'b000)
      $display("FAIL async_reset_release got=%b exp=000", {clk_oe, data_oe, busy});
    else passed++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({tx_ready, busy} !== 2'b10)
      $display("FAIL ready_after_reset got=%b exp=10", {tx_ready, busy});
    else passed++;
    d0 = done_cnt;
    run_frame(8'hFF, 11, 1'b1, bits, ok, seen);
    checks++;
    if (bits !== frame_of(8'hFF))
      $display("FAIL ff_bits got=%b exp=%b", bits, frame_of(8'hFF));
    else passed++;
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL ff_done got=%0d exp=1", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits1, bits2;
    bit ok1, ok2, seen, seen2;
    int ready_bad, d0;
    logic r_at_done, r_after, b_next;
    d0 = done_cnt;
    ready_bad = 0;
    seen = 1'b0;
    r_at_done = 1'bx;
    r_after = 1'bx;
    b_next = 1'bx;
    @(negedge clk_i);
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    fork
      dev_frame(11, 1'b1, bits1, ok1);
      begin
        @(negedge clk_i);
        for (int i = 0; i < int'(Inhibit) + 800 && !seen; i++) begin
          if (tx_done) begin
            seen = 1'b1;
          end else begin
            if (tx_ready) ready_bad++;
            @(negedge clk_i);
          end
        end
        r_at_done = tx_ready;
        tx_data = 8'h02;
        @(negedge clk_i);
        r_after = tx_ready;
        @(negedge clk_i);
        b_next = busy;
        tx_valid = 1'b0;
      end
    join
    dev_frame(11, 1'b1, bits2, ok2);
    wait_end(seen2);
    checks++;
    if (ready_bad !== 0) $display("FAIL b2b_ready_during got=%0d exp=0", ready_bad);
    else passed++;
    checks++;
    if ({seen, r_at_done, r_after, b_next} !== 4'b1011)
      $display("FAIL b2b_handoff got=%b exp=1011", {seen, r_at_done, r_after, b_next});
    else passed++;
    checks++;
    if (bits1 !== frame_of(8'hED))
      $display("FAIL b2b_first_bits got=%b exp=%b", bits1, frame_of(8'hED));
    else passed++;
    checks++;
    if (bits2 !== frame_of(8'h02))
      $display("FAIL b2b_second_bits got=%b exp=%b", bits2, frame_of(8'h02));
    else passed++;
    checks++;
    if (done_cnt - d0 !== 2) $display("FAIL b2b_done got=%0d exp=2", done_cnt - d0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_timeout();
    test_nack();
    test_reset_mid_frame();
    test_back_to_back();
    checks++;
    if (both_cnt !== 0) $display("FAIL done_err_overlap got=%0d exp=0", both_cnt);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 keyboard port; it is the counterpart of the existing scan-code receiver. It serializes one command byte at a time to the keyboard, for example 0xED set-LEDs followed by its argument, or 0xFF reset. It drives the open-drain PS/2 clock and data lines through active-high pull-low enables and reports device ACK, NACK or timeout. It sits beside the receiver on the same `ps2_clk`/`ps2_data` pins; the top level ties the enables to tri-state buffers.

## Interface
- `INHIBIT_CYCLES`, default 12000: `clk` cycles the host holds PS/2 clock low before the request (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 200000: maximum `clk` cycles without progress from the device (2 ms).
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `tx_data` in 8: command byte.
- `tx_valid` in 1: request to send `tx_data`.
- `tx_ready` out 1: high only in IDLE; a transfer starts when `tx_valid && tx_ready` at a rising edge of `clk`.
- `busy` out 1: high in every state except IDLE.
- `tx_done` out 1: one-cycle pulse when the device ACKed and the bus has returned to idle.
- `tx_err` out 1: one-cycle pulse when a transfer aborts.
- `err_code` out 2: valid while `tx_err` is high; 01 = timeout, 10 = NACK.
- `ps2_clk_i`, `ps2_data_i` in 1 each: raw pin levels, asynchronous to `clk`.
- `ps2_clk_oe`, `ps2_data_oe` out 1 each: 1 = pull the line low, 0 = release it.

## Operation
- **Line sampling.** Both pin inputs pass through 2-flop synchronizers. A falling edge (`fall`) is a synchronized clock transition from 1 to 0.
- **Parity.** The parity bit is odd parity of the command byte, `~^tx_data`. The byte is latched at acceptance.
- **Bit count.** A 4-bit counter `nfall` counts `fall` events after the clock is released.

States:
- **IDLE.** Both enables are 0. On accept, latch `tx_data`, compute parity, go to INHIBIT.
- **INHIBIT.** `ps2_clk_oe` = 1 for exactly `INHIBIT_CYCLES` cycles, then go to REQ.
- **REQ.** `ps2_clk_oe` = 1 and `ps2_data_oe` = 1 (start bit) for 1 cycle, then go to XFER.
- **XFER.** `ps2_clk_oe` = 0. The start bit is still driven. On each `fall`, `nfall` increments:
  - falls 1–8: drive data bit `nfall`−1, LSB first (`data_oe` = ~bit);
  - fall 9: drive the parity bit;
  - fall 10: release data (stop bit, `data_oe` = 0), then go to ACK.
- **ACK.** On the next `fall` (the 11th), sample synchronized data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: NACK, go to ERR.
- **WAIT_IDLE.** When both synchronized lines are high, go to DONE.
- **DONE.** Pulse `tx_done`, return to IDLE.
- **ERR.** Pulse `tx_err`, release both enables, return to IDLE.

Timeout:
- Active in XFER, ACK and WAIT_IDLE.
- A counter clears on state entry and on every `fall`, and increments otherwise.
- Reaching `TIMEOUT_CYCLES` sends the block to ERR with `err_code` = 01.

Other rules:
- `tx_valid` is ignored while `busy`. A held `tx_valid` is accepted again on the first IDLE cycle after DONE or ERR.
- Reset low at any time forces IDLE asynchronously and clears all outputs in the same instant, releasing the bus mid-frame.

## Timing
Reset values:
- `ps2_clk_oe` = 0, `ps2_data_oe` = 0, `tx_done` = 0, `tx_err` = 0, `err_code` = 00, `busy` = 0, `tx_ready` = 1.

Cycle-level behaviour:
- Acceptance at edge N: `ps2_clk_oe` rises at N+1 and stays high `INHIBIT_CYCLES` cycles, then 1 REQ cycle.
- All outputs are registered; enables change 1 cycle after the state or `nfall` update.
- `fall` is seen 3 `clk` cycles after the pin's falling edge (2 sync + 1 edge register). New data is therefore driven ≤ 4 cycles after the device's falling edge, well inside the ~30 µs low phase.
- A `fall` within the first cycles after the clock is released cannot be spurious. The synchronized clock is still low then, so no 1→0 transition exists until the device raises and drops the clock.
- A `fall` and the timeout limit in the same cycle: the `fall` wins.
- `tx_done` and `tx_err` are never high together. Each lasts exactly 1 cycle, and `tx_ready` returns the following cycle.

## Test plan
Bench uses `INHIBIT_CYCLES` = 100, `TIMEOUT_CYCLES` = 5000, and a device model clocking at a 40-cycle period with a 20-cycle low phase.

- **Send 0xED.** Device samples on its rising edges: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1. Device ACKs with data low on the 11th clock. Required: `tx_done` pulse once, no `tx_err`, `ps2_clk_oe` high for exactly 100 cycles.
- **Send 0x01.** Device sees parity 0. Send 0x00: device sees parity 1. Required: bits match, `tx_done` pulses.
- **Timeout.** Device never clocks. Required: `tx_err` with `err_code` = 01 exactly 5000 cycles after entering XFER; both enables 0 afterwards.
- **NACK.** Device leaves data high at the 11th clock. Required: `tx_err` with `err_code` = 10 and no `tx_done`.
- **Reset mid-frame.** Assert reset low after the 5th device clock. Required: `ps2_clk_oe` = `ps2_data_oe` = 0 immediately, without a `clk` edge; `tx_ready` = 1 after release. A following 0xFF transfer completes correctly.
- **Back-to-back.** Hold `tx_valid` with 0xED then 0x02. Required: the second byte is accepted only on the cycle after the first `tx_done`; `tx_ready` stays 0 throughout the first transfer.
